rcv_byte_assembler: RTL and testbench
=====================================

RCV_BYTE_ASSEMBLER -- requirements
Module: rcv_byte_assembler

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have port: n_rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: d_orig  in  1  NRZI-decoded receive bit, valid when shift_enable=1.
REQ-004 SHALL have port: shift_enable  in  1  one-cycle strobe at each bit-center sample.
REQ-005 SHALL have port: stuff_bit_detect  in  1  high means the current sampled bit is a stuff bit.
REQ-006 SHALL have port: eop  in  1  end-of-packet level, sampled only with shift_enable.
REQ-007 SHALL have port: rcv_data  out  8  last completed byte, LSB received first.
REQ-008 SHALL have port: byte_valid  out  1  one-cycle pulse per completed byte.
REQ-009 SHALL have port: rx_active  out  1  high while inside a packet (post-SYNC, pre-EOP).
REQ-010 SHALL have port: rx_error  out  1  one-cycle pulse on EOP with a partial byte.
REQ-011 SHALL have port: stuff_error  out  1  one-cycle pulse on a bad stuff bit (see REQ-027).

Function
REQ-012 SHALL implement FSM states IDLE, RECEIVE, plus a registered one-cycle output stage for pulses.
REQ-013 SHALL ignore d_orig, stuff_bit_detect and eop whenever shift_enable=0.
REQ-014 SHALL keep an 8-bit window: each accepted bit enters bit 7, the window shifts right, and the first bit of a byte ends in bit 0.
REQ-015 SHALL discard, without shifting or counting, any sampled bit with stuff_bit_detect=1, in every state.
REQ-016 In IDLE, SHALL shift every accepted bit into the window and go to RECEIVE when the window equals 8'h80 (SYNC, time order 0000_0001).
REQ-017 On the IDLE->RECEIVE transition, SHALL clear the window and the 3-bit bit counter, and assert rx_active the following cycle.
REQ-018 In RECEIVE, each accepted bit SHALL increment the bit counter modulo 8.
REQ-019 When the 8th bit (counter 7) is accepted, SHALL load rcv_data with the completed window and pulse byte_valid in the next cycle (latency 1 clock from the sampling edge).
REQ-020 rcv_data SHALL hold its value until the next completed byte; it SHALL NOT change on errors or EOP.
REQ-021 Priority on a shift_enable cycle in RECEIVE SHALL be eop > stuff_bit_detect > data.
REQ-022 eop with counter=0 SHALL return to IDLE, deassert rx_active next cycle, and raise no error.
REQ-023 eop with counter!=0 SHALL drop the partial byte, pulse rx_error, and return to IDLE.
REQ-024 eop in IDLE SHALL clear the window and have no other effect.
REQ-025 byte_valid, rx_error and stuff_error SHALL never be high for more than one consecutive cycle; shift_enable spacing is at least 2 clocks.

Reset
REQ-026 n_rst low SHALL immediately force IDLE, window=0, counter=0, rcv_data=8'h00, and byte_valid, rx_active, rx_error, stuff_error=0, including mid-byte.

Configuration
REQ-027 With macro STUFF_ERR_CHECK_EN defined, a stuff bit (stuff_bit_detect=1) sampled with d_orig=1 in RECEIVE SHALL pulse stuff_error, drop the partial byte, and return to IDLE.
REQ-028 Without STUFF_ERR_CHECK_EN, stuff_error SHALL be tied 0 and every stuff bit SHALL be discarded regardless of value.

Verification
REQ-029 Reset while mid-byte after 3 data bits -> all outputs 0, state IDLE on the next clock.
REQ-030 SYNC bits 0,0,0,0,0,0,0,1, then byte 0xA5 LSB-first -> rx_active=1, one byte_valid pulse 1 clock after the 8th sample, rcv_data=8'hA5.
REQ-031 SYNC, then byte 0x3F followed by a stuff 0 with stuff_bit_detect=1, then 0x00 -> rcv_data sequence 3F, 00, exactly 2 byte_valid pulses.
REQ-032 SYNC, byte 0x12, then eop after 5 more bits -> rx_error pulse, rx_active falls, rcv_data stays 8'h12.
REQ-033 SYNC, then a stuff bit with d_orig=1 -> with STUFF_ERR_CHECK_EN, stuff_error pulse and return to IDLE; without it, no pulse and reception continues.
REQ-034 Idle ones with interleaved stuff_bit_detect, then SYNC -> no byte_valid before SYNC; rx_active rises exactly once.

Source files
------------

// File: rtl/rcv_byte_assembler.sv
// rtl/rcv_byte_assembler.sv - receive bit-to-byte assembler with SYNC hunt, EOP and stuff handling
// Optional macro STUFF_ERR_CHECK_EN: a stuff bit sampled as 1 inside a packet aborts it with stuff_error.
module rcv_byte_assembler (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_orig,
    input  logic       shift_enable,
    input  logic       stuff_bit_detect,
    input  logic       eop,
    output logic [7:0] rcv_data,
    output logic       byte_valid,
    output logic       rx_active,
    output logic       rx_error,
    output logic       stuff_error
);

    typedef enum logic {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } state_t;

    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    state_t     r_state;
    logic [7:0] r_window;
    logic [2:0] r_bit_cnt;
    logic       r_win_full;
    logic [7:0] r_rcv_data;
    logic       r_byte_valid;
    logic       r_rx_active;
    logic       r_rx_error;
    logic       r_stuff_error;

    logic [7:0] w_shifted;
    logic       w_window_full;
    logic       w_bad_stuff;

    assign w_shifted = {d_orig, r_window[7:1]};

    // SYNC may only match once eight real bits have entered since the last clear,
    // otherwise a lone 1 after reset or EOP would look like 8'h80.
    assign w_window_full = r_win_full || (r_bit_cnt == 3'd7);

`ifdef STUFF_ERR_CHECK_EN
    assign w_bad_stuff = stuff_bit_detect & d_orig;
`else
    assign w_bad_stuff = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= IDLE;
            r_window      <= 8'h00;
            r_bit_cnt     <= 3'd0;
            r_win_full    <= 1'b0;
            r_rcv_data    <= 8'h00;
            r_byte_valid  <= 1'b0;
            r_rx_active   <= 1'b0;
            r_rx_error    <= 1'b0;
            r_stuff_error <= 1'b0;
        end else begin
            r_byte_valid  <= 1'b0;
            r_rx_error    <= 1'b0;
            r_stuff_error <= 1'b0;
            if (shift_enable) begin
                case (r_state)
                    IDLE: begin
                        if (eop) begin
                            r_window   <= 8'h00;
                            r_bit_cnt  <= 3'd0;
                            r_win_full <= 1'b0;
                        end else if (!stuff_bit_detect) begin
                            if (w_window_full && (w_shifted == SYNC_PATTERN)) begin
                                r_state     <= RECEIVE;
                                r_window    <= 8'h00;
                                r_bit_cnt   <= 3'd0;
                                r_win_full  <= 1'b0;
                                r_rx_active <= 1'b1;
                            end else begin
                                r_window  <= w_shifted;
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                                if (r_bit_cnt == 3'd7) begin
                                    r_win_full <= 1'b1;
                                end
                            end
                        end
                    end
                    RECEIVE: begin
                        if (eop) begin
                            r_rx_error  <= (r_bit_cnt != 3'd0);
                            r_state     <= IDLE;
                            r_window    <= 8'h00;
                            r_bit_cnt   <= 3'd0;
                            r_win_full  <= 1'b0;
                            r_rx_active <= 1'b0;
                        end else if (stuff_bit_detect) begin
                            if (w_bad_stuff) begin
                                r_stuff_error <= 1'b1;
                                r_state       <= IDLE;
                                r_window      <= 8'h00;
                                r_bit_cnt     <= 3'd0;
                                r_win_full    <= 1'b0;
                                r_rx_active   <= 1'b0;
                            end
                        end else begin
                            r_window  <= w_shifted;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_rcv_data   <= w_shifted;
                                r_byte_valid <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rcv_data    = r_rcv_data;
    assign byte_valid  = r_byte_valid;
    assign rx_active   = r_rx_active;
    assign rx_error    = r_rx_error;
    assign stuff_error = r_stuff_error;

endmodule

// File: tb/tb_rcv_byte_assembler.sv
// tb/tb_rcv_byte_assembler.sv - randomized self-checking bench for rcv_byte_assembler
module tb_rcv_byte_assembler;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       d_orig;
    logic       shift_enable;
    logic       stuff_bit_detect;
    logic       eop;
    logic [7:0] rcv_data;
    logic       byte_valid;
    logic       rx_active;
    logic       rx_error;
    logic       stuff_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rcv_byte_assembler dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .d_orig           (d_orig),
        .shift_enable     (shift_enable),
        .stuff_bit_detect (stuff_bit_detect),
        .eop              (eop),
        .rcv_data         (rcv_data),
        .byte_valid       (byte_valid),
        .rx_active        (rx_active),
        .rx_error         (rx_error),
        .stuff_error      (stuff_error)
    );

    // Reference model: packet flag, recent idle bits, bits of the byte in progress.
    bit         m_in_pkt;
    bit         m_hist[$];
    bit         m_bits[$];
    logic [7:0] m_data;
    logic       exp_bv, exp_rxerr, exp_serr;
    int         n_bv, n_rise;
    logic       prev_active;

    function automatic void model_reset();
        m_in_pkt = 1'b0;
        m_hist.delete();
        m_bits.delete();
        m_data = 8'h00;
    endfunction

    function automatic bit hist_is_sync();
        if (m_hist.size() != 8) return 1'b0;
        for (int i = 0; i < 7; i++) if (m_hist[i] != 1'b0) return 1'b0;
        return m_hist[7] == 1'b1;
    endfunction

    function automatic void leave_packet();
        m_in_pkt = 1'b0;
        m_hist.delete();
        m_bits.delete();
    endfunction

    function automatic void model_step(input bit d, input bit st, input bit e);
        exp_bv = 1'b0; exp_rxerr = 1'b0; exp_serr = 1'b0;
        if (!m_in_pkt) begin
            if (e) m_hist.delete();
            else if (!st) begin
                m_hist.push_back(d);
                if (m_hist.size() > 8) void'(m_hist.pop_front());
                if (hist_is_sync()) begin
                    m_in_pkt = 1'b1;
                    m_hist.delete();
                    m_bits.delete();
                end
            end
        end else begin
            if (e) begin
                exp_rxerr = (m_bits.size() != 0);
                leave_packet();
            end else if (st) begin
`ifdef STUFF_ERR_CHECK_EN
                if (d) begin
                    exp_serr = 1'b1;
                    leave_packet();
                end
`endif
            end else begin
                m_bits.push_back(d);
                if (m_bits.size() == 8) begin
                    for (int i = 0; i < 8; i++) m_data[i] = m_bits[i];
                    m_bits.delete();
                    exp_bv = 1'b1;
                end
            end
        end
    endfunction

    task automatic send_bit(input bit d, input bit st, input bit e);
        @(negedge clk);
        d_orig = d; stuff_bit_detect = st; eop = e; shift_enable = 1'b1;
        model_step(d, st, e);
        @(negedge clk);
        shift_enable = 1'b0;
        d_orig = 1'($urandom); stuff_bit_detect = 1'($urandom); eop = 1'($urandom);
        checks++;
        if (byte_valid !== exp_bv) begin
            errors++; $display("FAIL byte_valid got %b exp %b", byte_valid, exp_bv);
        end
        checks++;
        if (rcv_data !== m_data) begin
            errors++; $display("FAIL rcv_data got %h exp %h", rcv_data, m_data);
        end
        checks++;
        if (rx_active !== m_in_pkt) begin
            errors++; $display("FAIL rx_active got %b exp %b", rx_active, m_in_pkt);
        end
        checks++;
        if (rx_error !== exp_rxerr) begin
            errors++; $display("FAIL rx_error got %b exp %b", rx_error, exp_rxerr);
        end
        checks++;
        if (stuff_error !== exp_serr) begin
            errors++; $display("FAIL stuff_error got %b exp %b", stuff_error, exp_serr);
        end
        if (byte_valid === 1'b1) n_bv++;
        if (rx_active === 1'b1 && prev_active !== 1'b1) n_rise++;
        prev_active = rx_active;
        @(negedge clk);
        checks++;
        if ({byte_valid, rx_error, stuff_error} !== 3'b000) begin
            errors++; $display("FAIL pulse_width got %b exp 000", {byte_valid, rx_error, stuff_error});
        end
    endtask

    task automatic send_sync();
        for (int i = 0; i < 8; i++) send_bit(i == 7, 1'b0, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        n_rst = 1'b0; d_orig = 1'b0; shift_enable = 1'b0; stuff_bit_detect = 1'b0; eop = 1'b0;
        model_reset();
        prev_active = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rcv_data, byte_valid, rx_active, rx_error, stuff_error} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %h/%b%b%b%b exp 00/0000", rcv_data, byte_valid, rx_active, rx_error, stuff_error);
        end
        n_rst = 1'b1;
    endtask

    task automatic test_sync_byte();
        n_bv = 0;
        send_sync();
        send_byte(8'hA5);
        checks++;
        if (n_bv !== 1 || rcv_data !== 8'hA5) begin
            errors++; $display("FAIL sync_byte got n_bv=%0d data=%h exp 1 a5", n_bv, rcv_data);
        end
        send_bit(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_stuff_bit();
        n_bv = 0;
        send_sync();
        send_byte(8'h3F);
        send_bit(1'b0, 1'b1, 1'b0);
        send_byte(8'h00);
        checks++;
        if (n_bv !== 2 || rcv_data !== 8'h00) begin
            errors++; $display("FAIL stuff_discard got n_bv=%0d data=%h exp 2 00", n_bv, rcv_data);
        end
        send_bit(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_eop_partial();
        send_sync();
        send_byte(8'h12);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b1);
        checks++;
        if (rcv_data !== 8'h12 || rx_active !== 1'b0) begin
            errors++; $display("FAIL eop_partial got data=%h act=%b exp 12 0", rcv_data, rx_active);
        end
    endtask

    task automatic test_stuff_error();
        logic exp_act;
        send_sync();
        send_bit(1'b1, 1'b1, 1'b0);
`ifdef STUFF_ERR_CHECK_EN
        exp_act = 1'b0;
`else
        exp_act = 1'b1;
`endif
        checks++;
        if (rx_active !== exp_act) begin
            errors++; $display("FAIL stuff_one_active got %b exp %b", rx_active, exp_act);
        end
        send_byte(8'h5A);
        send_bit(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_idle_stuff();
        n_bv = 0; n_rise = 0; prev_active = rx_active;
        for (int i = 0; i < 12; i++) begin
            send_bit(1'b1, 1'b0, 1'b0);
            if (i % 3 == 2) send_bit(1'($urandom), 1'b1, 1'b0);
        end
        checks++;
        if (n_bv !== 0 || rx_active !== 1'b0) begin
            errors++; $display("FAIL idle_ones got n_bv=%0d act=%b exp 0 0", n_bv, rx_active);
        end
        send_sync();
        send_byte(8'hC3);
        checks++;
        if (n_rise !== 1 || n_bv !== 1) begin
            errors++; $display("FAIL idle_sync got rises=%0d n_bv=%0d exp 1 1", n_rise, n_bv);
        end
        send_bit(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_byte();
        send_sync();
        send_byte(8'h5C);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({rcv_data, byte_valid, rx_active, rx_error, stuff_error} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_byte got %h/%b%b%b%b exp 00/0000", rcv_data, byte_valid, rx_active, rx_error, stuff_error);
        end
        @(negedge clk);
        n_rst = 1'b1;
        prev_active = 1'b0;
        send_sync();
        send_byte(8'h96);
        send_bit(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int p = 0; p < 10; p++) begin
            int ng, nb;
            ng = $urandom_range(0, 6);
            for (int i = 0; i < ng; i++)
                send_bit(1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
            send_sync();
            nb = $urandom_range(0, 28);
            for (int i = 0; i < nb; i++)
                send_bit(1'($urandom), $urandom_range(0, 7) == 0, 1'b0);
            send_bit(1'($urandom), 1'b0, 1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sync_byte();
        test_stuff_bit();
        test_eop_partial();
        test_stuff_error();
        test_idle_stuff();
        test_reset_mid_byte();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
